// File: rtl/multi_timer_pkg.sv
// Shared constants for the multi-channel bus timer: register map, CTRL bit
// positions, mode encodings and the active-high/active-low enable levels.
package multi_timer_pkg;

  localparam logic [1:0] TIMER_ADDR_CTRL    = 2'd0;
  localparam logic [1:0] TIMER_ADDR_INTR    = 2'd1;
  localparam logic [1:0] TIMER_ADDR_EXPR    = 2'd2;
  localparam logic [1:0] TIMER_ADDR_COUNTER = 2'd3;

  localparam int CTRL_START_BIT  = 0;
  localparam int CTRL_MODE_BIT   = 1;
  localparam int CTRL_IRQ_EN_BIT = 2;
  localparam int CTRL_PS_BASE    = 8;
  localparam int CTRL_PS_MAX_W   = 32 - CTRL_PS_BASE;

  typedef enum logic {
    TIMER_MODE_ONE_SHOT = 1'b0,
    TIMER_MODE_PERIODIC = 1'b1
  } timer_mode_e;

  localparam logic ENABLE   = 1'b1;
  localparam logic DISABLE  = 1'b0;
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  // Assembles the CTRL read-back word; unused bits read as zero.
  function automatic logic [31:0] ctrl_word(input logic start, input logic mode,
                                            input logic irq_en,
                                            input logic [CTRL_PS_MAX_W-1:0] ps);
    logic [31:0] w;
    w = '0;
    w[CTRL_START_BIT]  = start;
    w[CTRL_MODE_BIT]   = mode;
    w[CTRL_IRQ_EN_BIT] = irq_en;
    w[CTRL_PS_BASE +: CTRL_PS_MAX_W] = ps;
    return w;
  endfunction

endpackage

// File: rtl/multi_timer_channel.sv
// One timer channel: CTRL/INTR/EXPR/COUNTER registers, prescaler and expiry.
// Bus decoding lives in the parent; this block only sees per-register strobes.
module timer_channel
  import multi_timer_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int PS_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_ctrl,
  input  logic             wr_intr,
  input  logic             wr_expr,
  input  logic             wr_cnt,
  input  logic [31:0]      wr_data,
  output logic             start,
  output logic             mode,
  output logic             irq_en,
  output logic [PS_W-1:0]  ps_val,
  output logic [CNT_W-1:0] expr_val,
  output logic [CNT_W-1:0] counter,
  output logic             irq,
  output logic             irq_masked
);

  logic [PS_W-1:0] ps_cnt;
  logic            tick;
  logic            expr;

  assign tick       = start && (ps_cnt == ps_val);
  assign expr       = tick && (counter == expr_val);
  assign irq_masked = irq & irq_en;

  // Prescaler restarts its divide period on any CTRL write or while stopped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ps_cnt <= '0;
    end else if (wr_ctrl || !start || tick) begin
      ps_cnt <= '0;
    end else begin
      ps_cnt <= ps_cnt + PS_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start  <= DISABLE;
      mode   <= TIMER_MODE_ONE_SHOT;
      irq_en <= DISABLE;
      ps_val <= '0;
    end else if (wr_ctrl) begin
      start  <= wr_data[CTRL_START_BIT];
      mode   <= wr_data[CTRL_MODE_BIT];
      irq_en <= wr_data[CTRL_IRQ_EN_BIT];
      ps_val <= wr_data[CTRL_PS_BASE +: PS_W];
    end else if (expr && (mode == TIMER_MODE_ONE_SHOT)) begin
      start <= DISABLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      expr_val <= '0;
    end else if (wr_expr) begin
      expr_val <= wr_data[CNT_W-1:0];
    end
  end

  // A bus load beats the expiry reload, which beats the normal increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      counter <= '0;
    end else if (wr_cnt) begin
      counter <= wr_data[CNT_W-1:0];
    end else if (expr) begin
      counter <= '0;
    end else if (tick) begin
      counter <= counter + CNT_W'(1);
    end
  end

  // Expiry wins over a same-cycle write-1-to-clear so no event is lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq <= DISABLE;
    end else if (expr) begin
      irq <= ENABLE;
    end else if (wr_intr && wr_data[0]) begin
      irq <= DISABLE;
    end
  end

endmodule

// File: rtl/multi_timer.sv
// Multi-channel timer slave: decodes {channel, reg} addresses, muxes register
// read-back, generates rdy_ and the combined active-low interrupt.
module multi_timer
  import multi_timer_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int PS_W   = 8,
  localparam int AW    = $clog2(NUM_CH) + 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cs_,
  input  logic          as_,
  input  logic          rw,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wr_data,
  output logic [31:0]   rd_data,
  output logic          rdy_,
  output logic          irq_
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic            access;
  logic [CH_W-1:0] ch_sel;
  logic [1:0]      reg_sel;
  logic            ch_valid;
  logic [31:0]     rd_mux;

  logic [NUM_CH-1:0] start;
  logic [NUM_CH-1:0] mode;
  logic [NUM_CH-1:0] irq_en;
  logic [NUM_CH-1:0] irq;
  logic [NUM_CH-1:0] irq_masked;
  logic [PS_W-1:0]   ps_val   [NUM_CH];
  logic [CNT_W-1:0]  expr_val [NUM_CH];
  logic [CNT_W-1:0]  counter  [NUM_CH];

  assign access  = !cs_ && !as_;
  assign reg_sel = addr[1:0];

  generate
    if (NUM_CH > 1) begin : g_ch_idx
      assign ch_sel = addr[AW-1:2];
    end else begin : g_ch_single
      assign ch_sel = 1'b0;
    end
  endgenerate

  // Indices past NUM_CH exist when NUM_CH is not a power of two.
  assign ch_valid = int'(ch_sel) < NUM_CH;

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic ch_wr;
      assign ch_wr = access && !rw && ch_valid && (ch_sel == CH_W'(i));

      timer_channel #(
        .CNT_W (CNT_W),
        .PS_W  (PS_W)
      ) u_channel (
        .clk        (clk),
        .reset      (reset),
        .wr_ctrl    (ch_wr && (reg_sel == TIMER_ADDR_CTRL)),
        .wr_intr    (ch_wr && (reg_sel == TIMER_ADDR_INTR)),
        .wr_expr    (ch_wr && (reg_sel == TIMER_ADDR_EXPR)),
        .wr_cnt     (ch_wr && (reg_sel == TIMER_ADDR_COUNTER)),
        .wr_data    (wr_data),
        .start      (start[i]),
        .mode       (mode[i]),
        .irq_en     (irq_en[i]),
        .ps_val     (ps_val[i]),
        .expr_val   (expr_val[i]),
        .counter    (counter[i]),
        .irq        (irq[i]),
        .irq_masked (irq_masked[i])
      );
    end
  endgenerate

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_sel == CH_W'(i)) begin
        case (reg_sel)
          TIMER_ADDR_CTRL:    rd_mux = ctrl_word(start[i], mode[i], irq_en[i],
                                                 CTRL_PS_MAX_W'(ps_val[i]));
          TIMER_ADDR_INTR:    rd_mux = 32'(irq[i]);
          TIMER_ADDR_EXPR:    rd_mux = 32'(expr_val[i]);
          TIMER_ADDR_COUNTER: rd_mux = 32'(counter[i]);
          default:            rd_mux = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data <= '0;
      rdy_    <= DISABLE_;
      irq_    <= DISABLE_;
    end else begin
      rd_data <= (access && rw) ? rd_mux : '0;
      rdy_    <= access ? ENABLE_ : DISABLE_;
      irq_    <= (|irq_masked) ? ENABLE_ : DISABLE_;
    end
  end

endmodule

// File: tb/tb_multi_timer.sv
// Self-checking bench for multi_timer (4 channels, 8-bit counters): directed
// scenarios followed by random bus traffic, all checked against a spec model.
module tb_multi_timer;

  localparam int NCH = 4;
  localparam int CW  = 8;
  localparam int PW  = 8;
  localparam int AW  = 4;
  localparam int CNT_MOD = 1 << CW;

  logic          clk = 1'b0;
  logic          reset;
  logic          cs_;
  logic          as_;
  logic          rw;
  logic [AW-1:0] addr;
  logic [31:0]   wr_data;
  logic [31:0]   rd_data;
  logic          rdy_;
  logic          irq_;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  multi_timer #(
    .NUM_CH (NCH),
    .CNT_W  (CW),
    .PS_W   (PW)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .cs_     (cs_),
    .as_     (as_),
    .rw      (rw),
    .addr    (addr),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .rdy_    (rdy_),
    .irq_    (irq_)
  );

  always #5 clk = ~clk;

  // Reference model: per-channel register contents as plain integers.
  int m_start [NCH];
  int m_mode  [NCH];
  int m_en    [NCH];
  int m_ps    [NCH];
  int m_psc   [NCH];
  int m_exp   [NCH];
  int m_cnt   [NCH];
  int m_irq   [NCH];
  logic [31:0] m_rd;
  logic        m_rdy;
  logic        m_irqn;
  logic        m_acc;
  logic        m_tick;
  logic        m_fire;
  logic        m_wr;
  int          m_ch;
  int          m_rg;

  function automatic logic [31:0] m_reg(input int ch, input int rg);
    case (rg)
      0:       return 32'(m_start[ch] + 2 * m_mode[ch] + 4 * m_en[ch] + 256 * m_ps[ch]);
      1:       return 32'(m_irq[ch]);
      2:       return 32'(m_exp[ch]);
      default: return 32'(m_cnt[ch]);
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        m_start[i] = 0; m_mode[i] = 0; m_en[i] = 0; m_ps[i] = 0;
        m_psc[i] = 0; m_exp[i] = 0; m_cnt[i] = 0; m_irq[i] = 0;
      end
      m_rd   = '0;
      m_rdy  = 1'b1;
      m_irqn = 1'b1;
    end else begin
      m_acc  = !cs_ && !as_;
      m_ch   = int'(addr[3:2]);
      m_rg   = int'(addr[1:0]);
      m_rd   = (m_acc && rw) ? m_reg(m_ch, m_rg) : 32'h0;
      m_rdy  = !m_acc;
      m_irqn = 1'b1;
      for (int i = 0; i < NCH; i++) begin
        if (m_irq[i] == 1 && m_en[i] == 1) m_irqn = 1'b0;
      end
      for (int i = 0; i < NCH; i++) begin
        m_tick = (m_start[i] == 1) && (m_psc[i] == m_ps[i]);
        m_fire = m_tick && (m_cnt[i] == m_exp[i]);
        m_wr   = m_acc && !rw && (m_ch == i);
        if ((m_wr && m_rg == 0) || m_start[i] == 0 || m_tick) m_psc[i] = 0;
        else m_psc[i] = m_psc[i] + 1;
        if (m_wr && m_rg == 3) m_cnt[i] = int'(wr_data % CNT_MOD);
        else if (m_fire) m_cnt[i] = 0;
        else if (m_tick) m_cnt[i] = (m_cnt[i] + 1) % CNT_MOD;
        if (m_wr && m_rg == 0) begin
          m_start[i] = int'(wr_data[0]);
          m_mode[i]  = int'(wr_data[1]);
          m_en[i]    = int'(wr_data[2]);
          m_ps[i]    = int'((wr_data >> 8) % 256);
        end else if (m_fire && m_mode[i] == 0) begin
          m_start[i] = 0;
        end
        if (m_wr && m_rg == 2) m_exp[i] = int'(wr_data % CNT_MOD);
        if (m_fire) m_irq[i] = 1;
        else if (m_wr && m_rg == 1 && wr_data[0]) m_irq[i] = 0;
      end
    end
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    check_output("model rd_data", rd_data, m_rd);
    check_output("model rdy_", {31'b0, rdy_}, {31'b0, m_rdy});
    check_output("model irq_", {31'b0, irq_}, {31'b0, m_irqn});
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic bus_write(input int ch, input int rg, input logic [31:0] d);
    cs_ = 1'b0; as_ = 1'b0; rw = 1'b0;
    addr = AW'(ch * 4 + rg);
    wr_data = d;
    step();
    cs_ = 1'b1; as_ = 1'b1;
  endtask

  task automatic bus_read(input int ch, input int rg, output logic [31:0] d);
    cs_ = 1'b0; as_ = 1'b0; rw = 1'b1;
    addr = AW'(ch * 4 + rg);
    step();
    d = rd_data;
    cs_ = 1'b1; as_ = 1'b1;
  endtask

  initial begin
    logic [31:0] v;
    int t0;
    int k;

    reset = 1'b1; cs_ = 1'b1; as_ = 1'b1; rw = 1'b1; addr = '0; wr_data = '0;
    idle(3);
    reset = 1'b0;
    step();
    check_output("reset rd_data", rd_data, 32'h0);
    check_output("reset rdy_", {31'b0, rdy_}, 32'h1);
    check_output("reset irq_", {31'b0, irq_}, 32'h1);
    bus_read(0, 0, v);
    check_output("read rdy_ low", {31'b0, rdy_}, 32'h0);
    step();
    check_output("idle rdy_ high", {31'b0, rdy_}, 32'h1);

    // One-shot on ch0: counts 0..5, expires 6 cycles after the CTRL write.
    bus_write(0, 2, 32'd5);
    bus_write(0, 0, 32'h5);
    for (int i = 0; i <= 5; i++) begin
      bus_read(0, 3, v);
      check_output("oneshot count", v, 32'(i));
    end
    step();
    check_output("oneshot irq_", {31'b0, irq_}, 32'h0);
    bus_read(0, 3, v); check_output("oneshot counter 0", v, 32'h0);
    bus_read(0, 0, v); check_output("oneshot stopped", v, 32'h4);
    bus_read(0, 1, v); check_output("oneshot intr", v, 32'h1);
    bus_write(0, 1, 32'h1);
    step();
    check_output("oneshot w1c irq_", {31'b0, irq_}, 32'h1);

    // Periodic ch2 with prescale 2: expiry every 12 cycles, never self-stops.
    bus_write(2, 2, 32'd3);
    bus_write(2, 0, 32'h207);
    t0 = cyc;
    idle(12);
    check_output("periodic pre irq_", {31'b0, irq_}, 32'h1);
    step();
    check_output("periodic first irq_", {31'b0, irq_}, 32'h0);
    bus_write(2, 1, 32'h1);
    step();
    check_output("periodic cleared irq_", {31'b0, irq_}, 32'h1);
    k = 0;
    while (irq_ !== 1'b0 && k < 20) begin
      step();
      k++;
    end
    check_output("periodic second expiry", 32'(cyc - t0), 32'd25);
    bus_read(2, 0, v); check_output("periodic still started", v, 32'h207);
    bus_write(2, 0, 32'h0);
    bus_write(2, 1, 32'h1);

    // Same-cycle collisions with a ch1 expiry.
    bus_write(1, 2, 32'd2);
    bus_write(1, 0, 32'h5);
    idle(2);
    bus_write(1, 1, 32'h1);
    bus_read(1, 1, v); check_output("w1c loses to expiry", v, 32'h1);
    bus_write(1, 1, 32'h1);
    bus_write(1, 0, 32'h5);
    idle(2);
    bus_write(1, 3, 32'h10);
    bus_read(1, 3, v); check_output("counter write wins", v, 32'h10);
    bus_read(1, 0, v); check_output("oneshot stop on collide", v, 32'h4);
    bus_write(1, 1, 32'h1);
    bus_write(1, 3, 32'h0);
    bus_write(1, 0, 32'h5);
    idle(2);
    bus_write(1, 0, 32'h5);
    bus_read(1, 0, v); check_output("ctrl write keeps start", v, 32'h5);
    bus_read(1, 1, v); check_output("ctrl collide irq", v, 32'h1);
    bus_write(1, 0, 32'h0);
    bus_write(1, 1, 32'h1);

    // Masking: ch0 unmasked-off, ch3 enabled.
    bus_write(0, 2, 32'd2);
    bus_write(3, 2, 32'd2);
    bus_write(0, 0, 32'h1);
    bus_write(3, 0, 32'h5);
    idle(3);
    check_output("masked ch0 irq_", {31'b0, irq_}, 32'h1);
    step();
    check_output("ch3 irq_", {31'b0, irq_}, 32'h0);
    bus_read(0, 1, v); check_output("masked ch0 latched", v, 32'h1);
    bus_write(3, 1, 32'h1);
    step();
    check_output("ch3 cleared irq_", {31'b0, irq_}, 32'h1);
    bus_read(0, 1, v); check_output("ch0 still latched", v, 32'h1);
    bus_write(0, 1, 32'h1);

    // Counter wrap at the 8-bit boundary; high write bits are discarded.
    bus_write(1, 2, 32'hABCD_12FF);
    bus_write(1, 3, 32'h1234_56FE);
    bus_write(1, 0, 32'h5);
    step();
    bus_read(1, 3, v); check_output("wrap counter ff", v, 32'hFF);
    bus_read(1, 3, v); check_output("wrap counter 0", v, 32'h0);
    bus_read(1, 1, v); check_output("wrap intr", v, 32'h1);
    bus_read(1, 2, v); check_output("expr zero-extended", v, 32'h0000_00FF);
    bus_write(1, 1, 32'h1);

    // Reset while ch1 counts and ch3 holds a pending interrupt.
    bus_write(1, 2, 32'h80);
    bus_write(1, 0, 32'h5);
    bus_write(3, 2, 32'h1);
    bus_write(3, 0, 32'h5);
    idle(4);
    check_output("pending irq_ before reset", {31'b0, irq_}, 32'h0);
    reset = 1'b1;
    #1;
    check_output("async reset irq_", {31'b0, irq_}, 32'h1);
    check_output("async reset rdy_", {31'b0, rdy_}, 32'h1);
    check_output("async reset rd_data", rd_data, 32'h0);
    idle(2);
    reset = 1'b0;
    bus_read(1, 3, v); check_output("reset ch1 counter", v, 32'h0);
    bus_read(1, 0, v); check_output("reset ch1 ctrl", v, 32'h0);
    bus_read(3, 1, v); check_output("reset ch3 intr", v, 32'h0);
    step();
    check_output("reset irq_ idle", {31'b0, irq_}, 32'h1);

    // Random traffic biased towards small values so channels expire often.
    repeat (600) begin
      cs_ = ($urandom_range(0, 3) == 0);
      as_ = ($urandom_range(0, 3) == 0);
      rw  = 1'($urandom_range(0, 1));
      addr = AW'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0:       wr_data = 32'($urandom_range(0, 7)) | (32'($urandom_range(0, 2)) << 8);
        1:       wr_data = 32'($urandom_range(0, 6));
        2:       wr_data = 32'h1;
        default: wr_data = $urandom;
      endcase
      reset = ($urandom_range(0, 299) == 0);
      step();
    end
    reset = 1'b0; cs_ = 1'b1; as_ = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
